ps2_mouse_rx: RTL and testbench

- Upstream stage of the SYMBiFACE II mouse port: turns raw PS/2 mouse clock and data lines into the 25-bit ps2_mouse packet bus.
- The SYMBiFACE mouse logic consumes that bus.
- Deserialises 11-bit PS/2 frames, checks framing and parity, resynchronises on packet byte 0, and publishes each complete 3-byte packet atomically with a toggle bit.

---
 rtl/ps2_mouse_rx.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ps2_mouse_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: PS/2 mouse receiver for the SYMBiFACE II mouse port.
// Latency: ps2_mouse updates 1 clk_sys after the falling edge that samples the final stop bit.
// Backpressure: none; the consumer watches ps2_mouse[24], which toggles on each new packet.
//
// Ports:
//   clk_sys, reset      system clock, synchronous active-high reset
//   ps2_clk_i           raw PS/2 clock line (asynchronous)
//   ps2_data_i          raw PS/2 data line (asynchronous)
//   ps2_mouse[24:0]     {toggle, dy, dx, status}, published atomically per packet
//   frame_err           one-cycle pulse when a byte or partial packet is dropped
//   ps2_clk_oe          (PS2M_INIT_EN only) 1 = pull PS/2 clock low
//   ps2_data_oe         (PS2M_INIT_EN only) 1 = pull PS/2 data low
//
// Optional feature macro PS2M_INIT_EN: sends 0xF4 (enable reporting) after reset
// and on hot-plug (0xAA 0x00), and publishes nothing until the 0xFA ack byte arrives.
module ps2_mouse_rx #(
  parameter int CLK_HZ     = 64000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
`ifdef PS2M_INIT_EN
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
`endif
  output logic [24:0] ps2_mouse,
  output logic        frame_err
);

  localparam longint TO_CYCLES = (longint'(TIMEOUT_US) * longint'(CLK_HZ)) / 64'sd1000000;
  localparam int     TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TO_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);

  // ---------------------------------------------------------------- input conditioning
  logic clk_meta, clk_s, data_meta, data_s;

  // Synchronisers reset to the idle-high bus level so reset does not fake an edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_s     <= 1'b1;
      data_meta <= 1'b1;
      data_s    <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_i;
      clk_s     <= clk_meta;
      data_meta <= ps2_data_i;
      data_s    <= data_meta;
    end
  end

  logic              clk_f;
  logic [FILT_W-1:0] filt_cnt;
  logic              flip, fe;

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  assign flip = (clk_s != clk_f) && (filt_cnt == FILT_LAST);
  assign fe   = flip && clk_f;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_f    <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == clk_f) begin
      filt_cnt <= '0;
    end else if (flip) begin
      clk_f    <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  // ---------------------------------------------------------------- shared control
  logic fe_rx;     // falling edge that belongs to the receive path
  logic pub_en;    // packets may be published
  logic rx_flush;  // drop any partial frame / packet
  logic to_fire;
  logic [1:0] idx;
  logic byte_done, byte_ok;
  logic [7:0] shift;

  // ---------------------------------------------------------------- frame FSM
  typedef enum logic {S_IDLE, S_BITS} rx_state_t;
  rx_state_t rx_state_q, rx_state_d;
  logic [3:0] bit_cnt;
  logic       par_q;

  always_ff @(posedge clk_sys) begin
    if (reset) rx_state_q <= S_IDLE;
    else       rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    if (to_fire || rx_flush) begin
      rx_state_d = S_IDLE;
    end else if (fe_rx) begin
      case (rx_state_q)
        S_IDLE:  if (!data_s) rx_state_d = S_BITS;
        S_BITS:  if (bit_cnt == 4'd10) rx_state_d = S_IDLE;
        default: rx_state_d = S_IDLE;
      endcase
    end
  end

  // The stop-bit edge completes the byte; odd parity over data+parity and stop==1.
  always_comb begin
    byte_done = 1'b0;
    byte_ok   = 1'b0;
    if (rx_state_q == S_BITS && fe_rx && bit_cnt == 4'd10) begin
      byte_done = 1'b1;
      byte_ok   = (^{shift, par_q}) && data_s;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt <= 4'd0;
      shift   <= 8'd0;
      par_q   <= 1'b0;
    end else if (to_fire || rx_flush) begin
      bit_cnt <= 4'd0;
    end else if (fe_rx) begin
      if (rx_state_q == S_IDLE) begin
        if (!data_s) bit_cnt <= 4'd1;
      end else if (bit_cnt == 4'd10) begin
        bit_cnt <= 4'd0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt <= 4'd8) shift <= {data_s, shift[7:1]};
        else                 par_q <= data_s;
      end
    end
  end

  // ---------------------------------------------------------------- inactivity timeout
  logic [TO_W-1:0] to_cnt;

  // Fires only on the cycle the counter reaches the limit, so a saturated
  // counter cannot pulse again; an fe in that cycle clears it instead.
  assign to_fire = !fe && (to_cnt == TO_LAST) && (rx_state_q != S_IDLE || idx != 2'd0);

  always_ff @(posedge clk_sys) begin
    if (reset)                 to_cnt <= '0;
    else if (fe)               to_cnt <= '0;
    else if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);
  end

  // ---------------------------------------------------------------- packet assembly
  logic [7:0] b0, b1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ps2_mouse <= 25'd0;
      frame_err <= 1'b0;
      idx       <= 2'd0;
      b0        <= 8'd0;
      b1        <= 8'd0;
    end else begin
      frame_err <= 1'b0;
      if (to_fire) begin
        idx       <= 2'd0;
        frame_err <= 1'b1;
      end else if (rx_flush) begin
        idx <= 2'd0;
      end else if (byte_done && !byte_ok) begin
        idx       <= 2'd0;
        frame_err <= 1'b1;
      end else if (byte_ok && pub_en) begin
        case (idx)
          2'd0: begin
            // Byte 0 always has bit 3 set; anything else means we are out of step.
            if (shift[3]) begin
              b0  <= shift;
              idx <= 2'd1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          2'd1: begin
            b1  <= shift;
            idx <= 2'd2;
          end
          default: begin
            ps2_mouse <= {~ps2_mouse[24], shift, b1, b0};
            idx       <= 2'd0;
          end
        endcase
      end
    end
  end

`ifdef PS2M_INIT_EN
  // ---------------------------------------------------------------- device init (0xF4)
  typedef enum logic [2:0] {I_START, I_HOLD, I_SEND, I_ACK, I_WAITFA, I_DONE} init_state_t;
  localparam int INIT_LIMIT = CLK_HZ / 50;            // 20 ms
  localparam int INIT_W     = $clog2(INIT_LIMIT + 1);
  localparam logic [INIT_W-1:0] HOLD_LAST = INIT_W'(CLK_HZ / 10000);  // 100 us
  localparam logic [INIT_W-1:0] WAIT_LAST = INIT_W'(INIT_LIMIT);
  localparam logic [7:0] CMD     = 8'hF4;
  localparam logic       CMD_PAR = ~^CMD;

  init_state_t       init_q, init_d;
  logic [INIT_W-1:0] init_cnt;
  logic [8:0]        tx_sh;
  logic [3:0]        tx_cnt;
  logic              data_oe_q;
  logic              aa_q;
  logic              hotplug;

  assign hotplug = pub_en && byte_ok && aa_q && idx == 2'd1 && shift == 8'h00;

  always_ff @(posedge clk_sys) begin
    if (reset) init_q <= I_START;
    else       init_q <= init_d;
  end

  always_comb begin
    init_d = init_q;
    case (init_q)
      I_START:  init_d = I_HOLD;
      I_HOLD:   if (init_cnt == HOLD_LAST) init_d = I_SEND;
      I_SEND:   if (fe && tx_cnt == 4'd9) init_d = I_ACK;
      I_ACK:    if (fe) init_d = data_s ? I_HOLD : I_WAITFA;
      I_WAITFA: if (byte_ok && shift == 8'hFA) init_d = I_DONE;
      I_DONE:   if (hotplug) init_d = I_HOLD;
      default:  init_d = I_HOLD;
    endcase
    // A silent device or a missing 0xFA restarts the command.
    if ((init_q == I_SEND || init_q == I_ACK || init_q == I_WAITFA) && init_cnt == WAIT_LAST)
      init_d = I_HOLD;
  end

  assign ps2_clk_oe  = (init_q == I_HOLD);
  assign ps2_data_oe = data_oe_q;
  assign pub_en      = (init_q == I_DONE);
  assign fe_rx       = fe && (init_q == I_WAITFA || init_q == I_DONE);
  assign rx_flush    = (init_d == I_HOLD) && (init_q != I_HOLD);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      init_cnt  <= '0;
      tx_sh     <= 9'd0;
      tx_cnt    <= 4'd0;
      data_oe_q <= 1'b0;
      aa_q      <= 1'b0;
    end else begin
      if (init_d != init_q)           init_cnt <= '0;
      else if (init_cnt != WAIT_LAST) init_cnt <= init_cnt + INIT_W'(1);

      if (init_q == I_HOLD) begin
        tx_sh     <= {CMD_PAR, CMD};
        tx_cnt    <= 4'd0;
        // Start bit: data goes low as the clock is released.
        data_oe_q <= (init_d == I_SEND);
      end else if (init_q == I_SEND && fe) begin
        // Edges 1..9 present data bits then parity; edge 10 releases for stop.
        tx_cnt    <= tx_cnt + 4'd1;
        data_oe_q <= (tx_cnt <= 4'd8) ? ~tx_sh[0] : 1'b0;
        tx_sh     <= {1'b0, tx_sh[8:1]};
      end

      if (rx_flush)       aa_q <= 1'b0;
      else if (byte_done) aa_q <= pub_en && byte_ok && idx == 2'd0 && shift == 8'hAA;
    end
  end
`else
  assign fe_rx    = fe;
  assign pub_en   = 1'b1;
  assign rx_flush = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Testbench for ps2_mouse_rx: directed vector table, timeout and mid-frame
// reset sequences, then random bytes checked against a queue-based packet model.
module tb_ps2_mouse_rx;
  localparam int CLK_HZ     = 4_000_000;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT_US = 2000;
  localparam int TO_CYC     = TIMEOUT_US * (CLK_HZ / 1_000_000);
  localparam int HALF       = 20;              // PS/2 clock half period in clk_sys cycles
  localparam int LAT        = 2 + FILTER_LEN;  // pin fall -> published (sync + filter)

  logic        clk_sys    = 1'b0;
  logic        reset      = 1'b1;
  logic        ps2_clk_i  = 1'b1;
  logic        ps2_data_i = 1'b1;
  logic [24:0] ps2_mouse;
  logic        frame_err;
`ifdef PS2M_INIT_EN
  logic        ps2_clk_oe, ps2_data_oe;
`endif

  ps2_mouse_rx #(.CLK_HZ(CLK_HZ), .FILTER_LEN(FILTER_LEN), .TIMEOUT_US(TIMEOUT_US)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
`ifdef PS2M_INIT_EN
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
`endif
    .ps2_mouse  (ps2_mouse),
    .frame_err  (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  int          cyc = 0;
  int          err_cnt = 0, dbl_err = 0, chg_cnt = 0, chg_cyc = 0, last_fall = 0;
  bit          mon_en = 1'b0;
  logic        prev_err = 1'b0;
  logic [24:0] prev_mouse = 25'd0;

  always @(posedge clk_sys) cyc++;

  always @(negedge clk_sys) begin
    if (mon_en) begin
      if (frame_err === 1'b1) begin
        err_cnt++;
        if (prev_err === 1'b1) dbl_err++;
      end
      if (ps2_mouse !== prev_mouse) begin
        chg_cnt++;
        chg_cyc = cyc;
      end
    end
    prev_err   = frame_err;
    prev_mouse = ps2_mouse;
  end

  // ---------------------------------------------------------------- reference model
  logic [24:0] exp_mouse = 25'd0;
  int          exp_err = 0, exp_chg = 0;
  logic [7:0]  pend[$];

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      pend.delete();
      exp_err++;
    end else if (pend.size() == 0 && !b[3]) begin
      exp_err++;
    end else begin
      pend.push_back(b);
      if (pend.size() == 3) begin
        exp_mouse = {~exp_mouse[24], pend[2], pend[1], pend[0]};
        exp_chg++;
        pend.delete();
      end
    end
  endfunction

  // ---------------------------------------------------------------- PS/2 device driver
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data_i = frame[i];
      wait_cyc(HALF / 2);
      ps2_clk_i = 1'b0;
      last_fall = cyc;
      wait_cyc(HALF);
      ps2_clk_i = 1'b1;
      wait_cyc(HALF / 2);
    end
    ps2_data_i = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] frame;
    logic        par;
    par   = (~^b) ^ bad_par;
    frame = {~bad_stop, par, b, 1'b0};
    send_bits(frame, 11);
    wait_cyc(2 * HALF);
    model_byte(b, !bad_par && !bad_stop);
  endtask

  // ---------------------------------------------------------------- directed table
  typedef struct {
    logic [7:0]  b;
    bit          bad_par;
    bit          bad_stop;
    logic [24:0] exp_mouse;
    int          exp_err;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int e0;
    logic [7:0] rb;
    bit bad, bstop;

    tbl[0]  = '{8'h09, 1'b0, 1'b0, 25'h0000000, 0};
    tbl[1]  = '{8'h05, 1'b0, 1'b0, 25'h0000000, 0};
    tbl[2]  = '{8'hFB, 1'b0, 1'b0, 25'h1FB0509, 0};
    tbl[3]  = '{8'h09, 1'b0, 1'b0, 25'h1FB0509, 0};
    tbl[4]  = '{8'h05, 1'b0, 1'b0, 25'h1FB0509, 0};
    tbl[5]  = '{8'hFB, 1'b0, 1'b0, 25'h0FB0509, 0};
    tbl[6]  = '{8'h09, 1'b0, 1'b0, 25'h0FB0509, 0};
    tbl[7]  = '{8'h05, 1'b1, 1'b0, 25'h0FB0509, 1};
    tbl[8]  = '{8'h08, 1'b0, 1'b0, 25'h0FB0509, 0};
    tbl[9]  = '{8'h01, 1'b0, 1'b0, 25'h0FB0509, 0};
    tbl[10] = '{8'h02, 1'b0, 1'b0, 25'h1020108, 0};
    tbl[11] = '{8'h00, 1'b0, 1'b0, 25'h1020108, 1};
    tbl[12] = '{8'h18, 1'b0, 1'b0, 25'h1020108, 0};
    tbl[13] = '{8'h7F, 1'b0, 1'b0, 25'h1020108, 0};
    tbl[14] = '{8'h80, 1'b0, 1'b0, 25'h0807F18, 0};
    tbl[15] = '{8'h09, 1'b0, 1'b1, 25'h0807F18, 1};

    // Reset state
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2);
    check("reset_mouse", 32'(ps2_mouse), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      e0 = err_cnt;
      send_byte(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop);
      check($sformatf("tbl%0d_mouse", i), 32'(ps2_mouse), 32'(tbl[i].exp_mouse));
      check($sformatf("tbl%0d_err", i), 32'(err_cnt - e0), 32'(tbl[i].exp_err));
      if (i > 0 && tbl[i].exp_mouse != tbl[i-1].exp_mouse)
        check($sformatf("tbl%0d_latency", i), 32'(chg_cyc - last_fall), 32'(LAT));
    end
    check("tbl_commits", 32'(chg_cnt), 32'(exp_chg));

    // Two bytes then silence: one timeout pulse, no commit
    send_byte(8'h09, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    wait_cyc(TO_CYC + 100);
    if (pend.size() != 0) exp_err++;
    pend.delete();
    check("timeout_err", 32'(err_cnt), 32'(exp_err));
    check("timeout_nocommit", 32'(chg_cnt), 32'(exp_chg));
    send_byte(8'h28, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    check("after_timeout_mouse", 32'(ps2_mouse), 32'h1221128);
    check("after_timeout_model", 32'(ps2_mouse), 32'(exp_mouse));

    // Reset after 5 bits of a frame
    send_byte(8'h09, 1'b0, 1'b0);
    e0 = err_cnt;
    send_bits({1'b1, 1'b1, 8'h05, 1'b0}, 5);
    mon_en = 1'b0;
    reset  = 1'b1;
    wait_cyc(3);
    reset  = 1'b0;
    wait_cyc(50);
    mon_en = 1'b1;
    exp_mouse = 25'd0;
    pend.delete();
    check("midreset_mouse", 32'(ps2_mouse), 32'h0);
    check("midreset_err", 32'(err_cnt - e0), 32'h0);
    send_byte(8'h0C, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    check("after_reset_mouse", 32'(ps2_mouse), 32'h101FF0C);

    // Random bytes against the model
    for (int i = 0; i < 40; i++) begin
      rb = 8'($urandom_range(0, 255));
      if (pend.size() == 0 && $urandom_range(0, 4) != 0) rb[3] = 1'b1;
      bad   = ($urandom_range(0, 7) == 0);
      bstop = bad && ($urandom_range(0, 1) == 1);
      send_byte(rb, bad && !bstop, bstop);
      check($sformatf("rnd%0d_mouse", i), 32'(ps2_mouse), 32'(exp_mouse));
      check($sformatf("rnd%0d_err", i), 32'(err_cnt), 32'(exp_err));
    end

    check("total_commits", 32'(chg_cnt), 32'(exp_chg));
    check("double_err_pulses", 32'(dbl_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
